// File: rtl/xbar_pkg.sv
// Shared types and widths for the crossbar response path.
package xbar_pkg;

    localparam int unsigned ROB_NUM_W   = 3;
    localparam int unsigned CH_ID_W     = 2;
    localparam int unsigned XBAR_DATA_W = 128;

    typedef enum logic [1:0] {
        FREE = 2'b00,
        PEND = 2'b01,
        DONE = 2'b10
    } rob_state_e;

endpackage

// File: rtl/xbar_rob_wr_sel.sv
// Per-entry write selection: picks the lowest-index bank port whose response
// targets each ROB entry and flags when more than one port hits the same entry.
module xbar_rob_wr_sel
    import xbar_pkg::*;
#(
    parameter int unsigned CH_ID     = 0,
    parameter int unsigned NUM_BANKS = 2,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned DATA_W    = XBAR_DATA_W
) (
    input  logic [NUM_BANKS-1:0]           valid_i,
    input  logic [CH_ID_W*NUM_BANKS-1:0]   ch_id_i,
    input  logic [ROB_NUM_W*NUM_BANKS-1:0] rob_num_i,
    input  logic [DATA_W*NUM_BANKS-1:0]    data_i,
    output logic [DEPTH-1:0]               wr_en_o,
    output logic [DEPTH*DATA_W-1:0]        wr_data_o,
    output logic                           collision_o
);

    logic [NUM_BANKS-1:0]            match;
    logic [DEPTH-1:0][NUM_BANKS-1:0] hit;
    logic [DEPTH-1:0]                coll;

    // Scanning from the top down lets the lowest-index hit overwrite the rest.
    function automatic logic [DATA_W-1:0] pick(
        input logic [NUM_BANKS-1:0]        h,
        input logic [DATA_W*NUM_BANKS-1:0] d
    );
        pick = '0;
        for (int b = NUM_BANKS - 1; b >= 0; b--) begin
            if (h[b]) begin
                pick = d[b*DATA_W +: DATA_W];
            end
        end
    endfunction

    generate
        for (genvar gb = 0; gb < NUM_BANKS; gb++) begin : g_match
            assign match[gb] = valid_i[gb]
                && (ch_id_i[gb*CH_ID_W +: CH_ID_W] == CH_ID_W'(CH_ID));
        end

        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            for (genvar gb = 0; gb < NUM_BANKS; gb++) begin : g_port
                assign hit[gi][gb] = match[gb]
                    && (rob_num_i[gb*ROB_NUM_W +: ROB_NUM_W] == ROB_NUM_W'(gi));
            end
            assign wr_en_o[gi]                    = |hit[gi];
            assign coll[gi]                       = (hit[gi] & (hit[gi] - NUM_BANKS'(1))) != '0;
            assign wr_data_o[gi*DATA_W +: DATA_W] = pick(hit[gi], data_i);
        end
    endgenerate

    assign collision_o = |coll;

endmodule

// File: rtl/xbar_ch_rob.sv
// Per-channel reorder buffer: captures out-of-order bank responses by tag and
// releases them to the channel strictly in allocation order.
module xbar_ch_rob
    import xbar_pkg::*;
#(
    parameter int unsigned CH_ID     = 0,
    parameter int unsigned NUM_BANKS = 2,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned DATA_W    = XBAR_DATA_W
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           alloc_req_i,
    output logic                           alloc_gnt_o,
    output logic [ROB_NUM_W-1:0]           alloc_rob_num_o,
    input  logic [NUM_BANKS-1:0]           bank_rsp_valid_i,
    input  logic [CH_ID_W*NUM_BANKS-1:0]   bank_rsp_ch_id_i,
    input  logic [ROB_NUM_W*NUM_BANKS-1:0] bank_rsp_rob_num_i,
    input  logic [DATA_W*NUM_BANKS-1:0]    bank_rsp_data_i,
    output logic                           rob_rsp_valid_o,
    input  logic                           rob_rsp_ready_i,
    output logic [ROB_NUM_W-1:0]           rob_rsp_rob_num_o,
    output logic [DATA_W-1:0]              rob_rsp_data_o,
    output logic [ROB_NUM_W:0]             rob_count_o,
    output logic                           rob_full_o,
    output logic                           rob_empty_o,
    output logic                           rob_err_o
);

    localparam int unsigned PTR_W = ROB_NUM_W + 1;

    rob_state_e           state_q [DEPTH];
    rob_state_e           state_d [DEPTH];
    logic [PTR_W-1:0]     head_q, head_d;
    logic [PTR_W-1:0]     tail_q, tail_d;
    logic                 err_q, err_d;
    logic [DATA_W-1:0]    mem_q [DEPTH];

    logic [DEPTH-1:0]        wr_hit;
    logic [DEPTH-1:0]        wr_ok;
    logic [DEPTH*DATA_W-1:0] wr_data;
    logic                    collision;
    logic [PTR_W-1:0]        count;
    logic                    full, gnt, pop, head_done;
    logic [ROB_NUM_W-1:0]    head_idx, tail_idx;

    xbar_rob_wr_sel #(
        .CH_ID     (CH_ID),
        .NUM_BANKS (NUM_BANKS),
        .DEPTH     (DEPTH),
        .DATA_W    (DATA_W)
    ) u_wr_sel (
        .valid_i     (bank_rsp_valid_i),
        .ch_id_i     (bank_rsp_ch_id_i),
        .rob_num_i   (bank_rsp_rob_num_i),
        .data_i      (bank_rsp_data_i),
        .wr_en_o     (wr_hit),
        .wr_data_o   (wr_data),
        .collision_o (collision)
    );

    assign head_idx  = head_q[ROB_NUM_W-1:0];
    assign tail_idx  = tail_q[ROB_NUM_W-1:0];
    assign count     = tail_q - head_q;
    assign full      = (count == PTR_W'(DEPTH));
    // Full is taken from registered pointers, so a same-cycle pop never frees a slot for alloc.
    assign gnt       = alloc_req_i & ~full;
    assign head_done = (state_q[head_idx] == DONE);
    assign pop       = head_done & rob_rsp_ready_i;

    always_comb begin
        state_d = state_q;
        err_d   = err_q | collision;
        wr_ok   = '0;
        head_d  = head_q + PTR_W'(pop);
        tail_d  = tail_q + PTR_W'(gnt);
        for (int e = 0; e < DEPTH; e++) begin
            // Only PEND entries accept data; FREE or DONE targets are protocol errors.
            if (wr_hit[e]) begin
                if (state_q[e] == PEND) begin
                    wr_ok[e]   = 1'b1;
                    state_d[e] = DONE;
                end else begin
                    err_d = 1'b1;
                end
            end
            if (gnt && (tail_idx == ROB_NUM_W'(e))) begin
                state_d[e] = PEND;
            end
            if (pop && (head_idx == ROB_NUM_W'(e))) begin
                state_d[e] = FREE;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int e = 0; e < DEPTH; e++) begin
                state_q[e] <= FREE;
            end
            head_q <= '0;
            tail_q <= '0;
            err_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            err_q   <= err_d;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
            always_ff @(posedge clk_i) begin
                if (wr_ok[gi]) begin
                    mem_q[gi] <= wr_data[gi*DATA_W +: DATA_W];
                end
            end
        end
    endgenerate

    assign alloc_gnt_o       = gnt;
    assign alloc_rob_num_o   = tail_idx;
    assign rob_rsp_valid_o   = head_done;
    assign rob_rsp_rob_num_o = head_idx;
    // Storage is not reset, so data is masked until the head entry is DONE.
    assign rob_rsp_data_o    = head_done ? mem_q[head_idx] : '0;
    assign rob_count_o       = count;
    assign rob_full_o        = full;
    assign rob_empty_o       = (count == '0);
    assign rob_err_o         = err_q;

endmodule

// File: tb/tb_xbar_ch_rob.sv
// Directed testbench for xbar_ch_rob with immediate-assertion checks.
module tb_xbar_ch_rob;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         alloc_req_i;
    logic         alloc_gnt_o;
    logic [2:0]   alloc_rob_num_o;
    logic [1:0]   bank_rsp_valid_i;
    logic [3:0]   bank_rsp_ch_id_i;
    logic [5:0]   bank_rsp_rob_num_i;
    logic [255:0] bank_rsp_data_i;
    logic         rob_rsp_valid_o;
    logic         rob_rsp_ready_i;
    logic [2:0]   rob_rsp_rob_num_o;
    logic [127:0] rob_rsp_data_o;
    logic [3:0]   rob_count_o;
    logic         rob_full_o;
    logic         rob_empty_o;
    logic         rob_err_o;

    int n_asrt = 0;
    int n_fail = 0;

    xbar_ch_rob #(
        .CH_ID     (0),
        .NUM_BANKS (2),
        .DEPTH     (8),
        .DATA_W    (128)
    ) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .alloc_req_i        (alloc_req_i),
        .alloc_gnt_o        (alloc_gnt_o),
        .alloc_rob_num_o    (alloc_rob_num_o),
        .bank_rsp_valid_i   (bank_rsp_valid_i),
        .bank_rsp_ch_id_i   (bank_rsp_ch_id_i),
        .bank_rsp_rob_num_i (bank_rsp_rob_num_i),
        .bank_rsp_data_i    (bank_rsp_data_i),
        .rob_rsp_valid_o    (rob_rsp_valid_o),
        .rob_rsp_ready_i    (rob_rsp_ready_i),
        .rob_rsp_rob_num_o  (rob_rsp_rob_num_o),
        .rob_rsp_data_o     (rob_rsp_data_o),
        .rob_count_o        (rob_count_o),
        .rob_full_o         (rob_full_o),
        .rob_empty_o        (rob_empty_o),
        .rob_err_o          (rob_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic bank(input int b, input logic [1:0] ch, input logic [2:0] tag,
                        input logic [127:0] d);
        bank_rsp_valid_i[b]          = 1'b1;
        bank_rsp_ch_id_i[b*2 +: 2]   = ch;
        bank_rsp_rob_num_i[b*3 +: 3] = tag;
        bank_rsp_data_i[b*128 +: 128] = d;
    endtask

    task automatic clear_banks();
        bank_rsp_valid_i   = '0;
        bank_rsp_ch_id_i   = '0;
        bank_rsp_rob_num_i = '0;
        bank_rsp_data_i    = '0;
    endtask

    task automatic do_reset();
        rst_i           = 1'b0;
        alloc_req_i     = 1'b0;
        rob_rsp_ready_i = 1'b0;
        clear_banks();
        tick();
        tick();
        rst_i = 1'b1;
        tick();
    endtask

    function automatic logic [127:0] dt(input int t);
        logic [31:0] w;
        w = 32'hC0DE0000 | 32'(t);
        return {4{w}};
    endfunction

    task automatic alloc_n(input int n, input int first);
        alloc_req_i = 1'b1;
        for (int i = 0; i < n; i++) begin
            #1;
            chk("alloc_gnt", 128'(alloc_gnt_o), 128'(1));
            chk("alloc_tag", 128'(alloc_rob_num_o), 128'(first + i));
            tick();
        end
        alloc_req_i = 1'b0;
    endtask

    localparam logic [127:0] DA = 128'hAAAA_0000_1111_2222_3333_4444_5555_6666;
    localparam logic [127:0] DB = 128'hBBBB_0000_7777_8888_9999_AAAA_BBBB_CCCC;
    localparam logic [127:0] DC = 128'hCCCC_1234;
    localparam logic [127:0] DD = 128'hDDDD_5678;
    localparam logic [127:0] DE = 128'hEEEE_9ABC;
    localparam logic [127:0] F0 = 128'hF0F0_F0F0_0000_0001;
    localparam logic [127:0] F1 = 128'hF1F1_F1F1_0000_0002;

    initial begin
        rst_i           = 1'b0;
        alloc_req_i     = 1'b0;
        rob_rsp_ready_i = 1'b0;
        clear_banks();
        #22;
        chk("rst_valid", 128'(rob_rsp_valid_o), 128'(0));
        chk("rst_gnt", 128'(alloc_gnt_o), 128'(0));
        chk("rst_alloc_tag", 128'(alloc_rob_num_o), 128'(0));
        chk("rst_rsp_tag", 128'(rob_rsp_rob_num_o), 128'(0));
        chk("rst_data", rob_rsp_data_o, 128'(0));
        chk("rst_count", 128'(rob_count_o), 128'(0));
        chk("rst_empty", 128'(rob_empty_o), 128'(1));
        chk("rst_full", 128'(rob_full_o), 128'(0));
        chk("rst_err", 128'(rob_err_o), 128'(0));
        rst_i = 1'b1;
        tick();

        // In-order fill to full, then one denied request.
        alloc_n(8, 0);
        chk("fill_count", 128'(rob_count_o), 128'(8));
        chk("fill_full", 128'(rob_full_o), 128'(1));
        alloc_req_i = 1'b1;
        #1;
        chk("full_gnt", 128'(alloc_gnt_o), 128'(0));
        alloc_req_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bank(0, 2'd0, 3'(i), 128'(i * 8'h11));
            tick();
            clear_banks();
            chk("inord_valid", 128'(rob_rsp_valid_o), 128'(1));
        end
        chk("inord_count", 128'(rob_count_o), 128'(8));

        // Pop and alloc together at full: no bypass.
        rob_rsp_ready_i = 1'b1;
        alloc_req_i     = 1'b1;
        #1;
        chk("pop0_tag", 128'(rob_rsp_rob_num_o), 128'(0));
        chk("pop0_data", rob_rsp_data_o, 128'(0));
        chk("nobypass_gnt", 128'(alloc_gnt_o), 128'(0));
        tick();
        chk("after_pop_count", 128'(rob_count_o), 128'(7));
        rob_rsp_ready_i = 1'b0;
        #1;
        chk("wrap_gnt", 128'(alloc_gnt_o), 128'(1));
        chk("wrap_tag", 128'(alloc_rob_num_o), 128'(0));
        tick();
        alloc_req_i = 1'b0;
        chk("wrap_count", 128'(rob_count_o), 128'(8));
        chk("wrap_full", 128'(rob_full_o), 128'(1));

        rob_rsp_ready_i = 1'b1;
        for (int i = 1; i < 8; i++) begin
            #1;
            chk("drain_valid", 128'(rob_rsp_valid_o), 128'(1));
            chk("drain_tag", 128'(rob_rsp_rob_num_o), 128'(i));
            chk("drain_data", rob_rsp_data_o, 128'(i * 8'h11));
            tick();
        end
        chk("wrapped_pend_valid", 128'(rob_rsp_valid_o), 128'(0));
        chk("wrapped_pend_count", 128'(rob_count_o), 128'(1));
        bank(1, 2'd0, 3'd0, 128'h99);
        tick();
        clear_banks();
        chk("wrapped_tag", 128'(rob_rsp_rob_num_o), 128'(0));
        chk("wrapped_data", rob_rsp_data_o, 128'h99);
        tick();
        rob_rsp_ready_i = 1'b0;
        chk("drain_empty", 128'(rob_empty_o), 128'(1));
        chk("drain_count", 128'(rob_count_o), 128'(0));
        chk("no_err_1", 128'(rob_err_o), 128'(0));

        // Out-of-order return.
        do_reset();
        alloc_n(4, 0);
        bank(1, 2'd0, 3'd3, dt(3)); tick(); clear_banks();
        chk("ooo_valid_a", 128'(rob_rsp_valid_o), 128'(0));
        bank(1, 2'd0, 3'd1, dt(1)); tick(); clear_banks();
        chk("ooo_valid_b", 128'(rob_rsp_valid_o), 128'(0));
        bank(1, 2'd0, 3'd2, dt(2)); tick(); clear_banks();
        chk("ooo_valid_c", 128'(rob_rsp_valid_o), 128'(0));
        bank(0, 2'd0, 3'd0, dt(0)); tick(); clear_banks();
        chk("ooo_valid_d", 128'(rob_rsp_valid_o), 128'(1));
        rob_rsp_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("ooo_tag", 128'(rob_rsp_rob_num_o), 128'(i));
            chk("ooo_data", rob_rsp_data_o, dt(i));
            tick();
        end
        rob_rsp_ready_i = 1'b0;
        chk("ooo_empty", 128'(rob_empty_o), 128'(1));

        // Channel filter, collision, DONE overwrite, multi-port capture.
        do_reset();
        alloc_n(3, 0);
        bank(0, 2'd1, 3'd0, DE); tick(); clear_banks();
        chk("filter_err", 128'(rob_err_o), 128'(0));
        chk("filter_valid", 128'(rob_rsp_valid_o), 128'(0));
        bank(0, 2'd0, 3'd2, DA);
        bank(1, 2'd0, 3'd2, DB);
        tick(); clear_banks();
        chk("coll_err", 128'(rob_err_o), 128'(1));
        bank(0, 2'd0, 3'd0, DC);
        bank(1, 2'd0, 3'd1, DD);
        tick(); clear_banks();
        chk("multi_valid", 128'(rob_rsp_valid_o), 128'(1));
        chk("multi_data0", rob_rsp_data_o, DC);
        bank(0, 2'd0, 3'd1, DE); tick(); clear_banks();
        rob_rsp_ready_i = 1'b1;
        #1;
        chk("c_tag0", 128'(rob_rsp_rob_num_o), 128'(0));
        chk("c_data0", rob_rsp_data_o, DC);
        tick();
        chk("c_data1_kept", rob_rsp_data_o, DD);
        tick();
        chk("c_tag2", 128'(rob_rsp_rob_num_o), 128'(2));
        chk("c_data2_lowport", rob_rsp_data_o, DA);
        tick();
        rob_rsp_ready_i = 1'b0;
        chk("c_empty", 128'(rob_empty_o), 128'(1));

        // Back-pressure, then reset mid-drain and a late response.
        do_reset();
        chk("reset_clears_err", 128'(rob_err_o), 128'(0));
        alloc_n(2, 0);
        bank(0, 2'd0, 3'd1, F1);
        bank(1, 2'd0, 3'd0, F0);
        tick(); clear_banks();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 128'(rob_rsp_valid_o), 128'(1));
            chk("bp_data", rob_rsp_data_o, F0);
            tick();
        end
        chk("bp_count", 128'(rob_count_o), 128'(2));
        rob_rsp_ready_i = 1'b1;
        tick();
        rob_rsp_ready_i = 1'b0;
        chk("bp_tag1", 128'(rob_rsp_rob_num_o), 128'(1));
        chk("bp_data1", rob_rsp_data_o, F1);
        #2;
        rst_i = 1'b0;
        #1;
        chk("mid_rst_valid", 128'(rob_rsp_valid_o), 128'(0));
        chk("mid_rst_tag", 128'(rob_rsp_rob_num_o), 128'(0));
        chk("mid_rst_data", rob_rsp_data_o, 128'(0));
        chk("mid_rst_count", 128'(rob_count_o), 128'(0));
        chk("mid_rst_empty", 128'(rob_empty_o), 128'(1));
        chk("mid_rst_err", 128'(rob_err_o), 128'(0));
        #2;
        rst_i = 1'b1;
        tick();
        bank(0, 2'd0, 3'd0, DE); tick(); clear_banks();
        chk("late_rsp_err", 128'(rob_err_o), 128'(1));
        chk("late_rsp_valid", 128'(rob_rsp_valid_o), 128'(0));
        chk("late_rsp_count", 128'(rob_count_o), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
